wb_master_arbiter: RTL and testbench

//  Two-master, one-slave Wishbone arbiter in front of wb_intercon's master port.
//  m0 = moxielite_wb core, m1 = gdbte_uart debug master; both share the 16-bit SoC bus.

---
 rtl/wb_master_arbiter_pkg.sv | 30 +++
 rtl/wb_arb_timer.sv | 27 ++
 rtl/wb_master_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_master_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: owner states double as the one-hot grant.
package wb_master_arbiter_pkg;

  localparam int GNT_M0 = 0;
  localparam int GNT_M1 = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  // Encoding equals the one-hot grant vector so gnt_o is the state register itself.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  function automatic state_t pick_owner(input logic req0, input logic req1,
                                        input logic rr, input logic last_m1);
    if (req0 && req1)
      return (rr && last_m1) ? ST_OWN0 : ST_OWN1;
    else if (req1)
      return ST_OWN1;
    else if (req0)
      return ST_OWN0;
    else
      return ST_IDLE;
  endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Stall counter with terminal-count flag; only present when WB_ARB_TIMEOUT_EN is defined.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (inc && !tc)
      count <= count + W'(1);
  end

  assign tc = (count == W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with cycle-locked grants.
// Optional stall timeout with error abort when WB_ARB_TIMEOUT_EN is defined.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_master_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  localparam logic RR = (ROUND_ROBIN != 0);

  state_t state;
  logic   last_m1;
  logic   owner_cyc;
  logic   elig0;
  logic   elig1;
  logic   timeout;

  assign owner_cyc = (state == ST_OWN0 && m0_cyc_i) || (state == ST_OWN1 && m1_cyc_i);

`ifdef WB_ARB_TIMEOUT_EN
  logic lock0;
  logic lock1;
  logic stall;
  logic tc;

  assign stall = s_cyc_o & s_stb_o & ~s_ack_i;

  // Entering IDLE always passes through a cycle with s_cyc_o low, so clearing
  // on ~s_cyc_o also covers every grant change.
  wb_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (s_ack_i | ~s_cyc_o | timeout),
    .inc   (stall),
    .tc    (tc)
  );

  assign timeout = tc & stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock0    <= 1'b0;
      lock1    <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
    end else begin
      m0_err_o <= timeout && (state == ST_OWN0);
      m1_err_o <= timeout && (state == ST_OWN1);
      if (timeout && state == ST_OWN0)
        lock0 <= 1'b1;
      else if (!m0_cyc_i)
        lock0 <= 1'b0;
      if (timeout && state == ST_OWN1)
        lock1 <= 1'b1;
      else if (!m1_cyc_i)
        lock1 <= 1'b0;
    end
  end

  assign elig0 = m0_cyc_i & ~lock0;
  assign elig1 = m1_cyc_i & ~lock1;
`else
  assign timeout  = 1'b0;
  assign elig0    = m0_cyc_i;
  assign elig1    = m1_cyc_i;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      last_m1 <= 1'b1;
    end else if (timeout) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE || !owner_cyc) begin
      state <= pick_owner(elig0, elig1, RR, last_m1);
      if (pick_owner(elig0, elig1, RR, last_m1) == ST_OWN0)
        last_m1 <= 1'b0;
      else if (pick_owner(elig0, elig1, RR, last_m1) == ST_OWN1)
        last_m1 <= 1'b1;
    end
  end

  assign gnt_o = state;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (state)
      ST_OWN0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
      end
      ST_OWN1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_o[GNT_M0];
  assign m1_ack_o = s_ack_i & gnt_o[GNT_M1];

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench: instance a uses fixed priority, instance b round-robin; both share stimulus.
// Expectations for the stall scenario depend on WB_ARB_TIMEOUT_EN.
module tb_wb_master_arbiter;
  import wb_master_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m0_adr, m1_adr;
  logic [15:0] m0_dat, m1_dat;
  logic [1:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [15:0] s_dat_i;
  logic        s_ack;

  logic [15:0] a_m0_dat_o, a_m1_dat_o, b_m0_dat_o, b_m1_dat_o;
  logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
  logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
  logic [31:0] a_s_adr, b_s_adr;
  logic [15:0] a_s_dat, b_s_dat;
  logic [1:0]  a_s_sel, b_s_sel, a_gnt, b_gnt;
  logic        a_s_we, a_s_cyc, a_s_stb, b_s_we, b_s_cyc, b_s_stb;

  wb_master_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) u_a (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .gnt_o(a_gnt)
  );

  wb_master_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .gnt_o(b_gnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    do_reset();

    // reset state
    chk("rst_gnt", 32'(a_gnt), 32'(GNT_NONE));
    chk("rst_scyc", 32'(a_s_cyc), 32'd0);
    chk("rst_sadr", a_s_adr, 32'd0);
    chk("rst_err0", 32'(a_m0_err), 32'd0);

    // 1: single m0 read
    m0_adr = 32'h0000_1000; m0_sel = 2'b11; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("t1_gnt_req_cycle", 32'(a_gnt), 32'(GNT_NONE));
    step();
    chk("t1_gnt", 32'(a_gnt), 32'(GNT_0));
    chk("t1_sadr", a_s_adr, 32'h0000_1000);
    chk("t1_scyc", 32'(a_s_cyc), 32'd1);
    chk("t1_ack_before", 32'(a_m0_ack), 32'd0);
    s_ack = 1'b1; s_dat_i = 16'hBEEF;
    #1;
    chk("t1_ack0", 32'(a_m0_ack), 32'd1);
    chk("t1_ack1", 32'(a_m1_ack), 32'd0);
    chk("t1_dat0", 32'(a_m0_dat_o), 32'h0000_BEEF);
    step();
    idle_all();
    step();
    step();
    chk("t1_back_idle", 32'(a_gnt), 32'(GNT_NONE));

    // 2: contention, fixed priority, zero-gap handoff
    do_reset();
    m0_adr = 32'h0000_1000; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h0000_2000; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("t2_gnt_m1", 32'(a_gnt), 32'(GNT_1));
    chk("t2_sadr_m1", a_s_adr, 32'h0000_2000);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    #1;
    chk("t2_scyc_drop", 32'(a_s_cyc), 32'd0);
    step();
    chk("t2_gnt_m0", 32'(a_gnt), 32'(GNT_0));
    chk("t2_sadr_m0", a_s_adr, 32'h0000_1000);
    idle_all();
    step();
    step();

    // 3: m0 locked across three beats while m1 waits
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    chk("t3_gnt_start", 32'(a_gnt), 32'(GNT_0));
    m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_beat_ack0", 32'(a_m0_ack), 32'd1);
      chk("t3_beat_ack1", 32'(a_m1_ack), 32'd0);
      step();
      chk("t3_gnt_held", 32'(a_gnt), 32'(GNT_0));
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    step();
    chk("t3_gnt_m1", 32'(a_gnt), 32'(GNT_1));
    idle_all();
    step();
    step();

    // 4: round-robin alternation from idle contention
    do_reset();
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      step();
      chk("t4_rr_gnt", 32'(b_gnt), (r % 2 == 0) ? 32'(GNT_0) : 32'(GNT_1));
      chk("t4_fixed_gnt", 32'(a_gnt), 32'(GNT_1));
      s_ack = 1'b1;
      step();
      idle_all();
      step();
    end

    // 5: slave never acks m0
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    chk("t5_gnt", 32'(a_gnt), 32'(GNT_0));
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t5_stall_gnt", 32'(a_gnt), 32'(GNT_0));
      chk("t5_stall_err", 32'(a_m0_err), 32'd0);
    end
    step();
`ifdef WB_ARB_TIMEOUT_EN
    chk("t5_to_gnt", 32'(a_gnt), 32'(GNT_NONE));
    chk("t5_to_scyc", 32'(a_s_cyc), 32'd0);
    chk("t5_to_err0", 32'(a_m0_err), 32'd1);
    chk("t5_to_err1", 32'(a_m1_err), 32'd0);
    step();
    chk("t5_err_pulse", 32'(a_m0_err), 32'd0);
    chk("t5_locked", 32'(a_gnt), 32'(GNT_NONE));
    step();
    chk("t5_still_locked", 32'(a_gnt), 32'(GNT_NONE));
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    step();
    chk("t5_regrant", 32'(a_gnt), 32'(GNT_0));
`else
    chk("t5_nt_gnt", 32'(a_gnt), 32'(GNT_0));
    chk("t5_nt_scyc", 32'(a_s_cyc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_nt_err", 32'(a_m0_err), 32'd0);
      step();
      chk("t5_nt_hold", 32'(a_gnt), 32'(GNT_0));
    end
`endif
    idle_all();
    step();
    step();

    // 6: reset in the middle of an m1 write beat
    do_reset();
    m1_adr = 32'h0000_3000; m1_dat = 16'h1234; m1_we = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("t6_gnt", 32'(a_gnt), 32'(GNT_1));
    chk("t6_swe", 32'(a_s_we), 32'd1);
    chk("t6_sdat", 32'(a_s_dat), 32'h0000_1234);
    s_ack = 1'b1; rst = 1'b1;
    step();
    chk("t6_rst_gnt", 32'(a_gnt), 32'(GNT_NONE));
    chk("t6_rst_scyc", 32'(a_s_cyc), 32'd0);
    chk("t6_rst_swe", 32'(a_s_we), 32'd0);
    chk("t6_rst_ack1", 32'(a_m1_ack), 32'd0);
    chk("t6_rst_ack0", 32'(a_m0_ack), 32'd0);
    chk("t6_rst_b_gnt", 32'(b_gnt), 32'(GNT_NONE));
    rst = 1'b0;
    idle_all();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
